// File: rtl/kf8259_ack_eoi_sequencer_pkg.sv
// Shared types, OCW2 command codes and level/bit helpers for the 8259 acknowledge/EOI path.
package KF8259_Common_Package;

  typedef enum logic [1:0] {
    ACK_IDLE = 2'd0,
    ACK_1    = 2'd1,
    ACK_2    = 2'd2,
    ACK_3    = 2'd3
  } ack_state_t;

  // OCW2 {R,SL,EOI} command field
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  function automatic logic [7:0] num2bit(input logic [2:0] num);
    return 8'b0000_0001 << num;
  endfunction

  function automatic logic [2:0] bit2num(input logic [7:0] one_hot);
    logic [2:0] num;
    num = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (one_hot[i]) num = 3'(i);
    end
    return num;
  endfunction

endpackage

// File: rtl/kf8259_ack_eoi_sequencer_eoi_decoder.sv
// OCW2 decode into registered EOI masks and the priority rotate register.
// Auto-EOI rotate mode exists only when KF8259_AUTO_EOI_EN is defined.
module kf8259_eoi_decoder
  import KF8259_Common_Package::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       ocw2_write,
  input  logic [7:0] ocw2_data,
  input  logic [7:0] highest_level_in_service,
  input  logic       aeoi_request,
  input  logic [7:0] aeoi_mask,
  output logic [7:0] end_of_interrupt,
  output logic [2:0] priority_rotate
);

  logic [2:0] cmd;
  logic [2:0] level;
  logic [7:0] ocw_mask;
  logic       ocw_rot_load;
  logic [2:0] ocw_rot_level;
  logic       rotate_in_aeoi;
  logic       unused_ocw2_bits;

  assign cmd              = ocw2_data[7:5];
  assign level            = ocw2_data[2:0];
  assign unused_ocw2_bits = ^ocw2_data[4:3];

  always_comb begin
    ocw_mask      = '0;
    ocw_rot_load  = 1'b0;
    ocw_rot_level = level;
    if (ocw2_write) begin
      case (cmd)
        OCW2_NS_EOI: ocw_mask = highest_level_in_service;
        OCW2_SP_EOI: ocw_mask = num2bit(level);
        OCW2_ROT_NS_EOI: begin
          ocw_mask      = highest_level_in_service;
          ocw_rot_load  = |highest_level_in_service;
          ocw_rot_level = bit2num(highest_level_in_service);
        end
        OCW2_ROT_SP_EOI: begin
          ocw_mask     = num2bit(level);
          ocw_rot_load = 1'b1;
        end
        OCW2_SET_PRI: ocw_rot_load = 1'b1;
        default: ;
      endcase
    end
  end

  // OCW2 and auto-EOI masks merge; an OCW2 rotate overrides an auto-EOI rotate
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      end_of_interrupt <= '0;
      priority_rotate  <= 3'd7;
    end else begin
      end_of_interrupt <= ocw_mask | (aeoi_request ? aeoi_mask : 8'h00);
      if (ocw_rot_load)
        priority_rotate <= ocw_rot_level;
      else if (aeoi_request && rotate_in_aeoi)
        priority_rotate <= bit2num(aeoi_mask);
    end
  end

`ifdef KF8259_AUTO_EOI_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      rotate_in_aeoi <= 1'b0;
    else if (ocw2_write && cmd == OCW2_ROT_AEOI_SET)
      rotate_in_aeoi <= 1'b1;
    else if (ocw2_write && cmd == OCW2_ROT_AEOI_CLR)
      rotate_in_aeoi <= 1'b0;
  end
`else
  assign rotate_in_aeoi = 1'b0;
`endif

endmodule

// File: rtl/kf8259_ack_eoi_sequencer.sv
// INTA pulse sequencer: latches the winning level, starts in-service, drives vector/CALL bytes.
// KF8259_AUTO_EOI_EN enables end-of-interrupt on the last INTA rising edge.
module kf8259_ack_eoi_sequencer
  import KF8259_Common_Package::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       interrupt_acknowledge_n,
  input  logic       u8086_mode,
  input  logic       auto_eoi_config,
  input  logic [4:0] vector_base,
  input  logic [2:0] call_address_low,
  input  logic [7:0] call_address_high,
  input  logic [7:0] highest_level_request,
  input  logic [7:0] highest_level_in_service,
  input  logic       ocw2_write,
  input  logic [7:0] ocw2_data,
  output logic       freeze,
  output logic       start_in_service,
  output logic [7:0] interrupt_to_service,
  output logic [7:0] clear_interrupt_request,
  output logic [7:0] end_of_interrupt,
  output logic [2:0] priority_rotate,
  output logic       out_control_logic_data,
  output logic [7:0] control_logic_data,
  output logic [1:0] debug_ack_state
);

  ack_state_t state;
  logic       prev_inta_n;
  logic [7:0] level_latch;
  logic       inta_fall;
  logic       inta_rise;
  logic       last_rise;
  logic [2:0] level_num;
  logic       aeoi_request;

  assign inta_fall       = prev_inta_n & ~interrupt_acknowledge_n;
  assign inta_rise       = ~prev_inta_n & interrupt_acknowledge_n;
  assign last_rise       = inta_rise & (((state == ACK_2) & u8086_mode) | (state == ACK_3));
  // A spurious acknowledge reports level 7
  assign level_num       = (level_latch == 8'h00) ? 3'd7 : bit2num(level_latch);
  assign debug_ack_state = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                   <= ACK_IDLE;
      prev_inta_n             <= 1'b1;
      level_latch             <= '0;
      freeze                  <= 1'b0;
      start_in_service        <= 1'b0;
      interrupt_to_service    <= '0;
      clear_interrupt_request <= '0;
      out_control_logic_data  <= 1'b0;
    end else begin
      prev_inta_n             <= interrupt_acknowledge_n;
      start_in_service        <= 1'b0;
      interrupt_to_service    <= '0;
      clear_interrupt_request <= '0;
      case (state)
        ACK_IDLE: begin
          if (inta_fall) begin
            state                  <= ACK_1;
            level_latch            <= highest_level_request;
            freeze                 <= 1'b1;
            out_control_logic_data <= ~u8086_mode;
            if (|highest_level_request) begin
              start_in_service        <= 1'b1;
              interrupt_to_service    <= highest_level_request;
              clear_interrupt_request <= highest_level_request;
            end
          end
        end
        ACK_1: begin
          if (inta_fall) begin
            state                  <= ACK_2;
            out_control_logic_data <= 1'b1;
          end else if (inta_rise) begin
            out_control_logic_data <= 1'b0;
          end
        end
        ACK_2: begin
          if (inta_fall && !u8086_mode) begin
            state                  <= ACK_3;
            out_control_logic_data <= 1'b1;
          end else if (inta_rise) begin
            out_control_logic_data <= 1'b0;
            if (u8086_mode) begin
              state  <= ACK_IDLE;
              freeze <= 1'b0;
            end
          end
        end
        default: begin
          if (inta_rise) begin
            state                  <= ACK_IDLE;
            freeze                 <= 1'b0;
            out_control_logic_data <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    control_logic_data = 8'h00;
    if (out_control_logic_data) begin
      case (state)
        ACK_1:   control_logic_data = CALL_OPCODE;
        ACK_2:   control_logic_data = u8086_mode ? {vector_base, level_num}
                                                 : {call_address_low, level_num, 2'b00};
        ACK_3:   control_logic_data = call_address_high;
        default: control_logic_data = 8'h00;
      endcase
    end
  end

`ifdef KF8259_AUTO_EOI_EN
  assign aeoi_request = last_rise & auto_eoi_config & (|level_latch);
`else
  logic unused_aeoi_inputs;
  assign unused_aeoi_inputs = auto_eoi_config & last_rise;
  assign aeoi_request       = 1'b0;
`endif

  kf8259_eoi_decoder u_eoi_decoder (
    .clock                    (clock),
    .reset                    (reset),
    .ocw2_write               (ocw2_write),
    .ocw2_data                (ocw2_data),
    .highest_level_in_service (highest_level_in_service),
    .aeoi_request             (aeoi_request),
    .aeoi_mask                (level_latch),
    .end_of_interrupt         (end_of_interrupt),
    .priority_rotate          (priority_rotate)
  );

endmodule

// File: tb/tb_kf8259_ack_eoi_sequencer.sv
// Directed bench for the INTA sequencer and OCW2 EOI/rotate decode.
module tb_kf8259_ack_eoi_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       interrupt_acknowledge_n = 1'b1;
  logic       u8086_mode = 1'b1;
  logic       auto_eoi_config = 1'b0;
  logic [4:0] vector_base = '0;
  logic [2:0] call_address_low = '0;
  logic [7:0] call_address_high = '0;
  logic [7:0] highest_level_request = '0;
  logic [7:0] highest_level_in_service = '0;
  logic       ocw2_write = 1'b0;
  logic [7:0] ocw2_data = '0;
  logic       freeze;
  logic       start_in_service;
  logic [7:0] interrupt_to_service;
  logic [7:0] clear_interrupt_request;
  logic [7:0] end_of_interrupt;
  logic [2:0] priority_rotate;
  logic       out_control_logic_data;
  logic [7:0] control_logic_data;
  logic [1:0] debug_ack_state;

  int tests  = 0;
  int failed = 0;

  kf8259_ack_eoi_sequencer dut (
    .clock                    (clock),
    .reset                    (reset),
    .interrupt_acknowledge_n  (interrupt_acknowledge_n),
    .u8086_mode               (u8086_mode),
    .auto_eoi_config          (auto_eoi_config),
    .vector_base              (vector_base),
    .call_address_low         (call_address_low),
    .call_address_high        (call_address_high),
    .highest_level_request    (highest_level_request),
    .highest_level_in_service (highest_level_in_service),
    .ocw2_write               (ocw2_write),
    .ocw2_data                (ocw2_data),
    .freeze                   (freeze),
    .start_in_service         (start_in_service),
    .interrupt_to_service     (interrupt_to_service),
    .clear_interrupt_request  (clear_interrupt_request),
    .end_of_interrupt         (end_of_interrupt),
    .priority_rotate          (priority_rotate),
    .out_control_logic_data   (out_control_logic_data),
    .control_logic_data       (control_logic_data),
    .debug_ack_state          (debug_ack_state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic inta_low();
    interrupt_acknowledge_n = 1'b0;
    tick();
  endtask

  task automatic inta_high();
    interrupt_acknowledge_n = 1'b1;
    tick();
  endtask

  task automatic ocw2(input logic [7:0] data);
    ocw2_write = 1'b1;
    ocw2_data  = data;
    tick();
    ocw2_write = 1'b0;
  endtask

  initial begin
    // reset state
    tick();
    tick();
    check("rst_freeze", 8'(freeze), 8'h00);
    check("rst_rotate", 8'(priority_rotate), 8'h07);
    check("rst_eoi", end_of_interrupt, 8'h00);
    check("rst_oe", 8'(out_control_logic_data), 8'h00);
    check("rst_state", 8'(debug_ack_state), 8'h00);
    reset = 1'b0;
    tick();

    // 8086, two pulses, request IR3
    u8086_mode = 1'b1; vector_base = 5'h10; highest_level_request = 8'h08;
    inta_low();
    check("x86_p1_start", 8'(start_in_service), 8'h01);
    check("x86_p1_its", interrupt_to_service, 8'h08);
    check("x86_p1_clr", clear_interrupt_request, 8'h08);
    check("x86_p1_freeze", 8'(freeze), 8'h01);
    check("x86_p1_oe", 8'(out_control_logic_data), 8'h00);
    check("x86_p1_state", 8'(debug_ack_state), 8'h01);
    tick();
    check("x86_start_1cyc", 8'(start_in_service), 8'h00);
    check("x86_clr_1cyc", clear_interrupt_request, 8'h00);
    inta_high();
    check("x86_gap_freeze", 8'(freeze), 8'h01);
    inta_low();
    check("x86_p2_oe", 8'(out_control_logic_data), 8'h01);
    check("x86_p2_byte", control_logic_data, 8'h83);
    check("x86_p2_start", 8'(start_in_service), 8'h00);
    inta_high();
    check("x86_end_oe", 8'(out_control_logic_data), 8'h00);
    check("x86_end_freeze", 8'(freeze), 8'h00);
    check("x86_end_state", 8'(debug_ack_state), 8'h00);

    // MCS-80, three pulses, request IR2
    u8086_mode = 1'b0; call_address_low = 3'b101; call_address_high = 8'h12;
    highest_level_request = 8'h04;
    inta_low();
    check("mcs_p1_byte", control_logic_data, 8'hCD);
    check("mcs_p1_start", 8'(start_in_service), 8'h01);
    check("mcs_p1_its", interrupt_to_service, 8'h04);
    inta_high();
    check("mcs_gap1_oe", 8'(out_control_logic_data), 8'h00);
    inta_low();
    check("mcs_p2_byte", control_logic_data, 8'hA8);
    inta_high();
    check("mcs_gap2_freeze", 8'(freeze), 8'h01);
    check("mcs_gap2_state", 8'(debug_ack_state), 8'h02);
    inta_low();
    check("mcs_p3_byte", control_logic_data, 8'h12);
    check("mcs_p3_state", 8'(debug_ack_state), 8'h03);
    inta_high();
    check("mcs_end_freeze", 8'(freeze), 8'h00);
    check("mcs_end_oe", 8'(out_control_logic_data), 8'h00);

    // spurious 8086 acknowledge
    u8086_mode = 1'b1; vector_base = 5'h10; highest_level_request = 8'h00;
    inta_low();
    check("spur_start", 8'(start_in_service), 8'h00);
    check("spur_clr", clear_interrupt_request, 8'h00);
    check("spur_freeze", 8'(freeze), 8'h01);
    inta_high();
    inta_low();
    check("spur_byte", control_logic_data, 8'h87);
    inta_high();

    // OCW2 decode
    highest_level_in_service = 8'h20;
    ocw2(8'hA0);
    check("rot_ns_eoi", end_of_interrupt, 8'h20);
    check("rot_ns_rot", 8'(priority_rotate), 8'h05);
    tick();
    check("rot_ns_eoi_1cyc", end_of_interrupt, 8'h00);
    ocw2(8'hC2);
    check("set_pri_rot", 8'(priority_rotate), 8'h02);
    check("set_pri_eoi", end_of_interrupt, 8'h00);
    ocw2(8'h20);
    check("ns_eoi", end_of_interrupt, 8'h20);
    check("ns_eoi_rot", 8'(priority_rotate), 8'h02);
    ocw2(8'h63);
    check("sp_eoi", end_of_interrupt, 8'h08);
    ocw2(8'hE6);
    check("rot_sp_eoi", end_of_interrupt, 8'h40);
    check("rot_sp_rot", 8'(priority_rotate), 8'h06);
    highest_level_in_service = 8'h00;
    ocw2(8'hA0);
    check("rot_ns_none_eoi", end_of_interrupt, 8'h00);
    check("rot_ns_none_rot", 8'(priority_rotate), 8'h06);
    ocw2(8'h40);
    check("nop_eoi", end_of_interrupt, 8'h00);
    check("nop_rot", 8'(priority_rotate), 8'h06);

    // reset between pulse 1 and pulse 2
    u8086_mode = 1'b1; highest_level_request = 8'h08;
    inta_low();
    inta_high();
    check("mid_pre_freeze", 8'(freeze), 8'h01);
    reset = 1'b1;
    #1;
    check("mid_rst_freeze", 8'(freeze), 8'h00);
    check("mid_rst_state", 8'(debug_ack_state), 8'h00);
    check("mid_rst_rot", 8'(priority_rotate), 8'h07);
    tick();
    reset = 1'b0;
    tick();

    // reset while a byte is on the bus
    u8086_mode = 1'b0;
    inta_low();
    check("drv_pre_oe", 8'(out_control_logic_data), 8'h01);
    reset = 1'b1;
    #1;
    check("drv_rst_oe", 8'(out_control_logic_data), 8'h00);
    check("drv_rst_byte", control_logic_data, 8'h00);
    interrupt_acknowledge_n = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    u8086_mode = 1'b1;
    inta_low();
    check("post_rst_state", 8'(debug_ack_state), 8'h01);
    check("post_rst_start", 8'(start_in_service), 8'h01);
    check("post_rst_its", interrupt_to_service, 8'h08);
    inta_high();
    inta_low();
    check("post_rst_byte", control_logic_data, 8'h83);
    inta_high();

    // auto-EOI with rotate-in-AEOI
    auto_eoi_config = 1'b1;
    ocw2(8'h80);
    highest_level_request = 8'h02;
    inta_low();
    tick();
    inta_high();
    inta_low();
    inta_high();
`ifdef KF8259_AUTO_EOI_EN
    check("aeoi_eoi", end_of_interrupt, 8'h02);
    check("aeoi_rot", 8'(priority_rotate), 8'h01);
`else
    check("aeoi_off_eoi", end_of_interrupt, 8'h00);
    check("aeoi_off_rot", 8'(priority_rotate), 8'h07);
`endif
    tick();
    check("aeoi_eoi_1cyc", end_of_interrupt, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
